uart_frame_assembler: RTL
=========================

Name: uart_frame_assembler

Overview:
- Sits between the UART RX byte output and the command decoder.
- Collects a fixed-length frame of bytes and checks that the end character matches byte 0, the opcode.
- Discards stale partial frames after an inter-byte timeout.
- Holds one checked frame in an output buffer with a valid/ready handshake. The decoder reads the opcode from bits [7:0] and the end character from the top byte.

Parameters:
- FRAME_BYTES, 18: bytes per frame. Legal range is 2..32.
- TIMEOUT_CYCLES, 2_000_000: idle clk cycles after which a partial frame is dropped. Must be ≥ 2.
- CNT_W, 21: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- nreset  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid while it is high.
- frame_out  out  8*FRAME_BYTES  assembled frame. The first received byte is at [7:0]; byte k is at [8k+7:8k].
- frame_valid  out  1  frame_out holds an unconsumed, checked frame.
- frame_ready  in  1  consumer accepts the frame when frame_valid && frame_ready.
- frame_err  out  1  one-cycle pulse when a completed frame fails the end-character check.
- timeout_err  out  1  one-cycle pulse when a partial frame is dropped.
- overflow_cnt  out  8  saturating count of checked frames dropped because the buffer was full.

Behaviour:
- Reset values (nreset low at a clk edge): frame_out=0, frame_valid=0, frame_err=0, timeout_err=0, overflow_cnt=0. The state machine goes to IDLE, the byte index to 0, the timer to 0.
- Reset has priority over every other event. A reset mid-frame drops the partial frame.
- State IDLE:
  - On rx_valid, store the byte at index 0, set idx=1, clear the timer, go to COLLECT.
- State COLLECT:
  - On rx_valid, store the byte at idx, idx++, clear the timer.
  - If the stored byte was at index FRAME_BYTES-1, go to CHECK.
  - With no rx_valid, the timer increments.
  - When the timer reaches TIMEOUT_CYCLES-1 with no rx_valid, pulse timeout_err, set idx=0, go to IDLE.
  - If rx_valid and the timeout coincide in the same cycle, the byte wins: it is stored and there is no timeout.
- State CHECK (one cycle), with byte 0 = opcode and end = byte FRAME_BYTES-1:
  - If end == byte 0 and frame_valid=0 (or frame_valid && frame_ready this cycle): load frame_out from the shadow buffer and set frame_valid=1 on the next edge.
  - If end == byte 0 and the buffer is full and not being consumed: keep frame_out unchanged, increment overflow_cnt (saturating at 255), and do not disturb frame_valid.
  - If end != byte 0: pulse frame_err and leave the buffer untouched.
  - Always return to IDLE with idx=0.
  - An rx_valid arriving during CHECK is treated as byte 0 of the next frame: store it, set idx=1, go to COLLECT.
- Latency: last byte strobed at edge N → frame_valid high after edge N+2.
- Throughput: back-to-back frames with no gap are supported.
- Shadow buffer: bytes assemble into an internal shadow register, so frame_out stays stable while frame_valid=1.
- Handshake:
  - frame_valid drops on the edge after a cycle with frame_valid && frame_ready, unless CHECK reloads in that same cycle; in that case frame_valid stays 1 and the new data appears.
  - frame_ready while frame_valid=0 is ignored.
- frame_err and timeout_err are never high in the same cycle.
- All widths are unsigned. idx has width clog2(FRAME_BYTES)+1 and never exceeds FRAME_BYTES-1.

Decomposition:
- Package uart_frame_pkg holds:
  - the state encoding: IDLE=2'd0, COLLECT=2'd1, CHECK=2'd2;
  - default constants FRAME_BYTES_DEF=18 and OVF_MAX=8'd255;
  - opcode characters shared with the decoder: "@", "A", "B", "C", "D", "a", "b".
- One sub-module, uart_idle_timer. It has inputs clk, nreset, clear and enable, and a one-cycle expired output. It encapsulates the timeout counter.

Test Plan:
- Reset behaviour: reset, then send 18 bytes "D"+"1w4n7myfl49p15"+"AA"+"D" → frame_valid=1 two cycles after the last strobe; frame_out[7:0]=8'h44, frame_out[143:136]=8'h44; frame_err never pulses.
- End-character mismatch: send 17 bytes of "B" then "C" → frame_err pulses once; frame_valid stays 0; overflow_cnt=0.
- Timeout (TIMEOUT_CYCLES=100): send 5 bytes then idle 100 cycles → timeout_err pulses exactly once; next a full valid "@…@" frame is accepted intact, with byte 0 = 8'h40.
- Buffer full: hold frame_ready=0 and send three valid frames back-to-back → only the first is in frame_out; overflow_cnt=2; raise frame_ready for 1 cycle → frame_valid falls next edge.
- Simultaneous consume and reload: assert frame_ready in the exact CHECK cycle of a second valid frame → frame_valid stays 1, frame_out switches to the second frame, overflow_cnt unchanged.
- Reset mid-operation: pull nreset low after byte 9 of a frame, release, send a full valid frame → all outputs read 0 during reset; the new frame is assembled with no residue from the partial frame.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame assembler and the command decoder.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2
    } state_e;

    localparam int         FRAME_BYTES_DEF = 18;
    localparam logic [7:0] OVF_MAX         = 8'd255;

    // Opcode characters understood by the command decoder.
    localparam logic [7:0] OP_AT      = 8'h40; // "@"
    localparam logic [7:0] OP_A       = 8'h41; // "A"
    localparam logic [7:0] OP_B       = 8'h42; // "B"
    localparam logic [7:0] OP_C       = 8'h43; // "C"
    localparam logic [7:0] OP_D       = 8'h44; // "D"
    localparam logic [7:0] OP_LOWER_A = 8'h61; // "a"
    localparam logic [7:0] OP_LOWER_B = 8'h62; // "b"

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle counter: counts enabled cycles and flags the cycle that reaches the limit.
module uart_idle_timer
    import uart_frame_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int CNT_W          = 21
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_limit;

    always_comb begin
        at_limit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        cnt_d    = cnt_q;
        if (clear || (enable && at_limit)) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = enable && !clear && at_limit;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles fixed-length UART frames, validates the end character against the opcode,
// and presents checked frames through a one-deep valid/ready output buffer.
module uart_frame_assembler
    import uart_frame_pkg::*;
#(
    parameter int FRAME_BYTES    = FRAME_BYTES_DEF,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int CNT_W          = 21
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic [8*FRAME_BYTES-1:0] frame_out,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     frame_err,
    output logic                     timeout_err,
    output logic [7:0]               overflow_cnt
);

    localparam int               W        = 8 * FRAME_BYTES;
    localparam int               IDX_W    = $clog2(FRAME_BYTES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, wr_idx;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     frame_q, frame_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             timeout_err_q, timeout_err_d;
    logic [7:0]       ovf_q, ovf_d;
    logic             store, end_match, timer_en, timer_exp;

    // The timer only runs on idle cycles inside a partial frame; any other cycle rewinds it.
    assign timer_en = (state_q == COLLECT) && !rx_valid;

    uart_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_idle_timer (
        .clk    (clk),
        .nreset (nreset),
        .clear  (!timer_en),
        .enable (timer_en),
        .expired(timer_exp)
    );

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        frame_d       = frame_q;
        ovf_d         = ovf_q;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        frame_valid_d = frame_valid_q && !frame_ready;
        store         = 1'b0;
        wr_idx        = '0;
        end_match     = (shadow_q[W-1 -: 8] == shadow_q[7:0]);

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    store   = 1'b1;
                    idx_d   = IDX_W'(1);
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    store  = 1'b1;
                    wr_idx = idx_q;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = CHECK;
                    end
                end else if (timer_exp) begin
                    timeout_err_d = 1'b1;
                    idx_d         = '0;
                    state_d       = IDLE;
                end
            end
            CHECK: begin
                if (!end_match) begin
                    frame_err_d = 1'b1;
                end else if (!frame_valid_q || frame_ready) begin
                    frame_d       = shadow_q;
                    frame_valid_d = 1'b1;
                end else if (ovf_q != OVF_MAX) begin
                    ovf_d = ovf_q + 8'd1;
                end
                idx_d   = '0;
                state_d = IDLE;
                // A byte arriving now opens the next frame; the load above still sees the old shadow.
                if (rx_valid) begin
                    store   = 1'b1;
                    idx_d   = IDX_W'(1);
                    state_d = COLLECT;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (store) begin
            for (int k = 0; k < FRAME_BYTES; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    shadow_d[8*k +: 8] = rx_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!nreset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            ovf_q         <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            ovf_q         <= ovf_d;
        end
    end

    assign frame_out    = frame_q;
    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;
    assign timeout_err  = timeout_err_q;
    assign overflow_cnt = ovf_q;

endmodule
